// File: rtl/cuadro_painter.sv
// cuadro_painter: repaints the 4x2 grid of colour squares into the frame buffer, one pixel per clock.
// Build option PAINT_DIRTY_ONLY_EN: repaint only changed squares instead of the whole frame.
module cuadro_painter #(
   parameter int AW       = 15,
   parameter int DW       = 3,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int SQ_W     = 40,
   parameter int SQ_H     = 60
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] cuadroColores0,
   input  logic [DW-1:0] cuadroColores1,
   input  logic [DW-1:0] cuadroColores2,
   input  logic [DW-1:0] cuadroColores3,
   input  logic [DW-1:0] cuadroColores4,
   input  logic [DW-1:0] cuadroColores5,
   input  logic [DW-1:0] cuadroColores6,
   input  logic [DW-1:0] cuadroColores7,
   output logic [AW-1:0] mem_px_addr,
   output logic [DW-1:0] mem_px_data,
   output logic          px_wr,
   output logic          busy,
   output logic          done,
   output logic [2:0]    dbg_state
);

   localparam int NPIX = SCREEN_W * SCREEN_H;
   localparam int XW   = (SQ_W > 1) ? $clog2(SQ_W) : 1;
   localparam int YW   = (SQ_H > 1) ? $clog2(SQ_H) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(SQ_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(SQ_H - 1);
   localparam logic [AW-1:0] LINE_STEP = AW'(SCREEN_W - SQ_W + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_PAINT = 3'd2,
      S_NEXT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [7:0][DW-1:0]     shadow_q, shadow_d;
   logic [7:0]             dirty_q, dirty_d;
   logic [2:0]             sel_q, sel_d;
   logic [XW-1:0]          x_q, x_d;
   logic [YW-1:0]          y_q, y_d;
   logic [AW-1:0]          addr_q, addr_d;
   logic [DW-1:0]          data_q, data_d;
   logic                   wr_q, wr_d;

   logic [7:0][DW-1:0]     col_in;
   logic [7:0]             diff;
   logic [7:0]             dirty_upd;
   logic [2:0]             load_sq;
   logic [2:0]             next_sq;

   // Top-left pixel of square idx: row = idx[2], col = idx[1:0].
   function automatic logic [AW-1:0] base_of(input logic [2:0] idx);
      logic [AW-1:0] row_off;
      logic [AW-1:0] col_off;
      row_off = idx[2] ? AW'(SQ_H * SCREEN_W) : '0;
      col_off = AW'(SQ_W * int'(idx[1:0]));
      return row_off + col_off;
   endfunction

   function automatic logic [2:0] lowest(input logic [7:0] m);
      logic [2:0] r;
      r = '0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) r = 3'(i);
      end
      return r;
   endfunction

   assign col_in = {cuadroColores7, cuadroColores6, cuadroColores5, cuadroColores4,
                    cuadroColores3, cuadroColores2, cuadroColores1, cuadroColores0};

   always_comb begin
      diff = '0;
      for (int i = 0; i < 8; i++) begin
         diff[i] = (col_in[i] != shadow_q[i]);
      end
   end

`ifdef PAINT_DIRTY_ONLY_EN
   assign dirty_upd = dirty_q | diff;
`else
   assign dirty_upd = (|diff) ? 8'hFF : dirty_q;
`endif

   // LOAD re-evaluates the compare so a change landing between IDLE and the snapshot is not lost.
   assign load_sq = lowest(dirty_upd);
   assign next_sq = lowest(dirty_q);

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      dirty_d  = dirty_q;
      sel_d    = sel_q;
      x_d      = x_q;
      y_d      = y_q;
      addr_d   = addr_q;
      data_d   = data_q;
      wr_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (|dirty_upd) begin
               dirty_d = dirty_upd;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            shadow_d = col_in;
            dirty_d  = dirty_upd;
            sel_d    = load_sq;
            addr_d   = base_of(load_sq);
            data_d   = col_in[load_sq];
            x_d      = '0;
            y_d      = '0;
            wr_d     = 1'b1;
            state_d  = S_PAINT;
         end
         S_PAINT: begin
            if (x_q == X_LAST) begin
               x_d = '0;
               if (y_q == Y_LAST) begin
                  dirty_d[sel_q] = 1'b0;
                  state_d        = S_NEXT;
               end else begin
                  y_d    = y_q + YW'(1);
                  addr_d = addr_q + LINE_STEP;
                  wr_d   = 1'b1;
               end
            end else begin
               x_d    = x_q + XW'(1);
               addr_d = addr_q + AW'(1);
               wr_d   = 1'b1;
            end
         end
         S_NEXT: begin
            if (|dirty_q) begin
               sel_d   = next_sq;
               addr_d  = base_of(next_sq);
               data_d  = shadow_q[next_sq];
               x_d     = '0;
               y_d     = '0;
               wr_d    = 1'b1;
               state_d = S_PAINT;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // All squares start dirty so the first pass after reset paints the full frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         shadow_q <= '0;
         dirty_q  <= '1;
         sel_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         wr_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         dirty_q  <= dirty_d;
         sel_q    <= sel_d;
         x_q      <= x_d;
         y_q      <= y_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         wr_q     <= wr_d;
      end
   end

   assign mem_px_addr = addr_q;
   assign mem_px_data = data_q;
   assign px_wr       = wr_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign dbg_state   = state_q;

   a_addr_in_frame: assert property (@(posedge clk) disable iff (rst)
      wr_q |-> (32'(addr_q) < NPIX));

endmodule
